// File: rtl/tcdm_arb_mux_pkg.sv
// Shared TCDM interconnect constants and bus field types.
package pkg_soc_interconnect;

    localparam int unsigned TCDM_ADDR_WIDTH = 32;
    localparam int unsigned TCDM_DATA_WIDTH = 32;
    localparam int unsigned TCDM_BE_WIDTH   = TCDM_DATA_WIDTH / 8;

    typedef logic [TCDM_ADDR_WIDTH-1:0] tcdm_addr_t;
    typedef logic [TCDM_DATA_WIDTH-1:0] tcdm_data_t;
    typedef logic [TCDM_BE_WIDTH-1:0]   tcdm_be_t;

endpackage

// File: rtl/tcdm_arb_mux_if.sv
// TCDM request/response bus with 32-bit address and data.
interface XBAR_TCDM_BUS_36;
    import pkg_soc_interconnect::*;

    logic       req;
    tcdm_addr_t add;
    logic       wen;
    tcdm_data_t wdata;
    tcdm_be_t   be;
    logic       gnt;
    logic       r_valid;
    tcdm_data_t r_rdata;
    logic       r_opc;

    modport Master (
        output req, add, wen, wdata, be,
        input  gnt, r_valid, r_rdata, r_opc
    );

    modport Slave (
        input  req, add, wen, wdata, be,
        output gnt, r_valid, r_rdata, r_opc
    );

endinterface

// File: rtl/tcdm_macros.svh
// Helpers that flatten TCDM interface ports into plain per-field signals.
`ifndef TCDM_MACROS_SVH
`define TCDM_MACROS_SVH

`define TCDM_EXPLODE_SLAVE(port, idx, sReq, sAdd, sWen, sWdata, sBe, sGnt, sRValid, sRRdata, sROpc) \
    assign sReq[idx]     = port.req;      \
    assign sAdd[idx]     = port.add;      \
    assign sWen[idx]     = port.wen;      \
    assign sWdata[idx]   = port.wdata;    \
    assign sBe[idx]      = port.be;       \
    assign port.gnt      = sGnt[idx];     \
    assign port.r_valid  = sRValid[idx];  \
    assign port.r_rdata  = sRRdata[idx];  \
    assign port.r_opc    = sROpc[idx];

`define TCDM_EXPLODE_MASTER(port, mReq, mAdd, mWen, mWdata, mBe, mGnt, mRValid, mRRdata, mROpc) \
    assign port.req      = mReq;          \
    assign port.add      = mAdd;          \
    assign port.wen      = mWen;          \
    assign port.wdata    = mWdata;        \
    assign port.be       = mBe;           \
    assign mGnt          = port.gnt;      \
    assign mRValid       = port.r_valid;  \
    assign mRRdata       = port.r_rdata;  \
    assign mROpc         = port.r_opc;

`endif

// File: rtl/tcdm_rr_sel.sv
// Round-robin winner selection with a lock that pins the winner while the
// target withholds its grant.
module tcdm_rr_sel #(
    parameter  int unsigned NR_INPUTS = 2,
    localparam int unsigned SEL_WIDTH = $clog2(NR_INPUTS)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NR_INPUTS-1:0] req_i,
    input  logic                 handshake_i,
    input  logic                 lock_i,
    output logic [SEL_WIDTH-1:0] idx_o
);

    logic [SEL_WIDTH-1:0] last_q, last_d;
    logic [SEL_WIDTH-1:0] lock_idx_q, lock_idx_d;
    logic [SEL_WIDTH-1:0] rr_idx, cand_idx;
    logic                 lock_q, lock_d;
    int                   cand;

    // Scan from lowest to highest priority so the last hit is the winner.
    always_comb begin
        rr_idx   = '0;
        cand     = 0;
        cand_idx = '0;
        for (int k = NR_INPUTS; k >= 1; k--) begin
            cand     = (int'(last_q) + k) % int'(NR_INPUTS);
            cand_idx = SEL_WIDTH'(cand);
            if (req_i[cand_idx]) rr_idx = cand_idx;
        end
        idx_o = (lock_q && req_i[lock_idx_q]) ? lock_idx_q : rr_idx;
    end

    always_comb begin
        last_d     = handshake_i ? idx_o : last_q;
        lock_d     = lock_i;
        lock_idx_d = lock_i ? idx_o : lock_idx_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q     <= SEL_WIDTH'(NR_INPUTS - 1);
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            last_q     <= last_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

endmodule

// File: rtl/tcdm_arb_mux.sv
// Arbitrates NR_INPUTS TCDM requesters onto one target, allowing a single
// outstanding transaction and routing each response back to its owner.
`include "tcdm_macros.svh"

module tcdm_arb_mux
    import pkg_soc_interconnect::*;
#(
    parameter int unsigned NR_INPUTS = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            test_en_i,
    XBAR_TCDM_BUS_36.Slave  in_ports [NR_INPUTS],
    XBAR_TCDM_BUS_36.Master out_port
);

    localparam int unsigned SEL_WIDTH = $clog2(NR_INPUTS);

    typedef enum logic {IDLE, PENDING} state_e;

    state_e               state_q, state_d;
    logic [SEL_WIDTH-1:0] owner_q, owner_d;
    logic [SEL_WIDTH-1:0] winner;
    logic                 handshake, stall;
    logic                 unused_test_en;

    logic [NR_INPUTS-1:0] in_req, in_wen, in_gnt, in_r_valid, in_r_opc;
    tcdm_addr_t           in_add     [NR_INPUTS];
    tcdm_data_t           in_wdata   [NR_INPUTS];
    tcdm_be_t             in_be      [NR_INPUTS];
    tcdm_data_t           in_r_rdata [NR_INPUTS];

    logic       out_req, out_wen, out_gnt, out_r_valid, out_r_opc;
    tcdm_addr_t out_add;
    tcdm_data_t out_wdata, out_r_rdata;
    tcdm_be_t   out_be;

    for (genvar i = 0; i < NR_INPUTS; i++) begin : g_explode
        `TCDM_EXPLODE_SLAVE(in_ports[i], i, in_req, in_add, in_wen, in_wdata, in_be, in_gnt, in_r_valid, in_r_rdata, in_r_opc)
    end
    `TCDM_EXPLODE_MASTER(out_port, out_req, out_add, out_wen, out_wdata, out_be, out_gnt, out_r_valid, out_r_rdata, out_r_opc)

    assign unused_test_en = test_en_i;
    assign stall          = out_req & ~out_gnt;

    tcdm_rr_sel #(
        .NR_INPUTS (NR_INPUTS)
    ) i_rr_sel (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (in_req),
        .handshake_i (handshake),
        .lock_i      (stall),
        .idx_o       (winner)
    );

    // A new request may only go out while idle or in the cycle the pending
    // response returns; reset forces the request low immediately.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        out_req    = 1'b0;
        in_gnt     = '0;
        in_r_valid = '0;
        in_r_opc   = '0;
        for (int i = 0; i < NR_INPUTS; i++) in_r_rdata[i] = '0;
        unique case (state_q)
            IDLE: out_req = rst_ni & (|in_req);
            PENDING: begin
                in_r_valid[owner_q] = out_r_valid;
                in_r_rdata[owner_q] = out_r_rdata;
                in_r_opc[owner_q]   = out_r_opc;
                out_req             = rst_ni & out_r_valid & (|in_req);
                if (out_r_valid) state_d = IDLE;
            end
        endcase
        handshake      = out_req & out_gnt;
        in_gnt[winner] = handshake;
        if (handshake) begin
            state_d = PENDING;
            owner_d = winner;
        end
    end

    always_comb begin
        out_add   = '0;
        out_wen   = 1'b1;
        out_wdata = '0;
        out_be    = '0;
        if (|in_req) begin
            out_add   = in_add[winner];
            out_wen   = in_wen[winner];
            out_wdata = in_wdata[winner];
            out_be    = in_be[winner];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

endmodule

// File: tb/tb_tcdm_arb_mux.sv
// Directed-vector bench for tcdm_arb_mux with four requesters and a
// hand-driven target.
module tb_tcdm_arb_mux;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req;
    logic [31:0] add [4];
    logic [3:0]  wen;
    logic [31:0] wdata [4];
    logic [3:0]  be [4];
    logic [3:0]  gnt, r_valid, r_opc;
    logic [31:0] r_rdata [4];
    logic        t_gnt, t_r_valid, t_r_opc;
    logic [31:0] t_r_rdata;
    int          checks = 0;
    int          passes = 0;

    XBAR_TCDM_BUS_36 in_bus [4] ();
    XBAR_TCDM_BUS_36 out_bus ();

    for (genvar g = 0; g < 4; g++) begin : g_in
        assign in_bus[g].req   = req[g];
        assign in_bus[g].add   = add[g];
        assign in_bus[g].wen   = wen[g];
        assign in_bus[g].wdata = wdata[g];
        assign in_bus[g].be    = be[g];
        assign gnt[g]          = in_bus[g].gnt;
        assign r_valid[g]      = in_bus[g].r_valid;
        assign r_rdata[g]      = in_bus[g].r_rdata;
        assign r_opc[g]        = in_bus[g].r_opc;
    end

    assign out_bus.gnt     = t_gnt;
    assign out_bus.r_valid = t_r_valid;
    assign out_bus.r_rdata = t_r_rdata;
    assign out_bus.r_opc   = t_r_opc;

    tcdm_arb_mux #(
        .NR_INPUTS (4)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .test_en_i (1'b0),
        .in_ports  (in_bus),
        .out_port  (out_bus)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        req       = 4'b0000;
        wen       = 4'b1111;
        t_gnt     = 1'b0;
        t_r_valid = 1'b0;
        t_r_rdata = 32'h0;
        t_r_opc   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            add[i]   = 32'h0;
            wdata[i] = 32'h0;
            be[i]    = 4'h0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req       = 4'b0101;
        t_gnt     = 1'b1;
        t_r_valid = 1'b1;
        #1;
        checks++; if (out_bus.req !== 1'b0) $display("[TB] FAIL reset_out_req: got %b expected 0", out_bus.req); else passes++;
        checks++; if (gnt !== 4'b0000) $display("[TB] FAIL reset_gnt: got %b expected 0000", gnt); else passes++;
        checks++; if (r_valid !== 4'b0000) $display("[TB] FAIL reset_r_valid: got %b expected 0000", r_valid); else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        clear_inputs();
        #1;
        checks++; if (out_bus.req !== 1'b0) $display("[TB] FAIL idle_out_req: got %b expected 0", out_bus.req); else passes++;
        checks++; if (out_bus.add !== 32'h0) $display("[TB] FAIL idle_add: got %h expected 00000000", out_bus.add); else passes++;
        checks++; if (out_bus.wen !== 1'b1) $display("[TB] FAIL idle_wen: got %b expected 1", out_bus.wen); else passes++;
        checks++; if (out_bus.wdata !== 32'h0) $display("[TB] FAIL idle_wdata: got %h expected 00000000", out_bus.wdata); else passes++;
        checks++; if (out_bus.be !== 4'h0) $display("[TB] FAIL idle_be: got %h expected 0", out_bus.be); else passes++;
    endtask

    task automatic test_single_read();
        @(negedge clk);
        req[0]  = 1'b1;
        add[0]  = 32'h1C00_0000;
        wen[0]  = 1'b1;
        be[0]   = 4'hF;
        t_gnt   = 1'b1;
        #1;
        checks++; if (out_bus.req !== 1'b1) $display("[TB] FAIL read_out_req: got %b expected 1", out_bus.req); else passes++;
        checks++; if (out_bus.add !== 32'h1C00_0000) $display("[TB] FAIL read_add: got %h expected 1c000000", out_bus.add); else passes++;
        checks++; if (gnt !== 4'b0001) $display("[TB] FAIL read_gnt: got %b expected 0001", gnt); else passes++;
        checks++; if (r_valid !== 4'b0000) $display("[TB] FAIL read_r_valid_c0: got %b expected 0000", r_valid); else passes++;
        @(negedge clk);
        req[0]    = 1'b0;
        t_gnt     = 1'b0;
        t_r_valid = 1'b1;
        t_r_rdata = 32'hDEAD_BEEF;
        t_r_opc   = 1'b1;
        #1;
        checks++; if (r_valid !== 4'b0001) $display("[TB] FAIL read_r_valid_c1: got %b expected 0001", r_valid); else passes++;
        checks++; if (r_rdata[0] !== 32'hDEAD_BEEF) $display("[TB] FAIL read_rdata0: got %h expected deadbeef", r_rdata[0]); else passes++;
        checks++; if (r_rdata[1] !== 32'h0) $display("[TB] FAIL read_rdata1: got %h expected 00000000", r_rdata[1]); else passes++;
        checks++; if (r_opc !== 4'b0001) $display("[TB] FAIL read_r_opc: got %b expected 0001", r_opc); else passes++;
        checks++; if (out_bus.req !== 1'b0) $display("[TB] FAIL read_no_req: got %b expected 0", out_bus.req); else passes++;
        @(negedge clk);
        #1;
        checks++; if (r_valid !== 4'b0000) $display("[TB] FAIL read_late_r_valid: got %b expected 0000", r_valid); else passes++;
        clear_inputs();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt, exp_rv;
        int         w, pw;
        do_reset();
        for (int i = 0; i < 4; i++) add[i] = 32'h1C00_1000 + 32'(i * 4);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            req       = 4'b1111;
            t_gnt     = 1'b1;
            t_r_valid = (k > 0);
            t_r_rdata = 32'h100 + 32'(k);
            #1;
            w       = k % 4;
            exp_gnt = 4'b0001 << w;
            checks++; if (gnt !== exp_gnt) $display("[TB] FAIL rr_gnt[%0d]: got %b expected %b", k, gnt, exp_gnt); else passes++;
            checks++; if (out_bus.add !== 32'h1C00_1000 + 32'(w * 4)) $display("[TB] FAIL rr_add[%0d]: got %h expected %h", k, out_bus.add, 32'h1C00_1000 + 32'(w * 4)); else passes++;
            if (k > 0) begin
                pw     = (k - 1) % 4;
                exp_rv = 4'b0001 << pw;
                checks++; if (r_valid !== exp_rv) $display("[TB] FAIL rr_r_valid[%0d]: got %b expected %b", k, r_valid, exp_rv); else passes++;
                checks++; if (r_rdata[pw] !== 32'h100 + 32'(k)) $display("[TB] FAIL rr_rdata[%0d]: got %h expected %h", k, r_rdata[pw], 32'h100 + 32'(k)); else passes++;
            end
        end
        @(negedge clk);
        req       = 4'b0000;
        t_gnt     = 1'b0;
        t_r_valid = 1'b1;
        #1;
        checks++; if (r_valid !== 4'b1000) $display("[TB] FAIL rr_last_r_valid: got %b expected 1000", r_valid); else passes++;
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_stall_lock();
        // in1 wins first so that plain round-robin would now favour in2 over in0
        @(negedge clk);
        req[1] = 1'b1;
        add[1] = 32'h1C00_0020;
        t_gnt  = 1'b1;
        @(negedge clk);
        req[1]    = 1'b0;
        t_gnt     = 1'b0;
        t_r_valid = 1'b1;
        @(negedge clk);
        t_r_valid = 1'b0;
        req[0]    = 1'b1;
        add[0]    = 32'h1C00_0040;
        #1;
        checks++; if (out_bus.add !== 32'h1C00_0040) $display("[TB] FAIL stall_add0: got %h expected 1c000040", out_bus.add); else passes++;
        checks++; if (gnt !== 4'b0000) $display("[TB] FAIL stall_gnt0: got %b expected 0000", gnt); else passes++;
        for (int s = 1; s < 3; s++) begin
            @(negedge clk);
            req[2] = 1'b1;
            add[2] = 32'h1C00_0080;
            #1;
            checks++; if (out_bus.add !== 32'h1C00_0040) $display("[TB] FAIL stall_add%0d: got %h expected 1c000040", s, out_bus.add); else passes++;
            checks++; if (gnt !== 4'b0000) $display("[TB] FAIL stall_gnt%0d: got %b expected 0000", s, gnt); else passes++;
        end
        @(negedge clk);
        t_gnt = 1'b1;
        #1;
        checks++; if (gnt !== 4'b0001) $display("[TB] FAIL stall_grant_in0: got %b expected 0001", gnt); else passes++;
        checks++; if (out_bus.add !== 32'h1C00_0040) $display("[TB] FAIL stall_grant_add: got %h expected 1c000040", out_bus.add); else passes++;
        @(negedge clk);
        req[0]    = 1'b0;
        t_r_valid = 1'b1;
        t_r_rdata = 32'h0000_0A0A;
        #1;
        checks++; if (r_valid !== 4'b0001) $display("[TB] FAIL stall_r_valid_in0: got %b expected 0001", r_valid); else passes++;
        checks++; if (gnt !== 4'b0100) $display("[TB] FAIL stall_grant_in2: got %b expected 0100", gnt); else passes++;
        checks++; if (out_bus.add !== 32'h1C00_0080) $display("[TB] FAIL stall_add_in2: got %h expected 1c000080", out_bus.add); else passes++;
        @(negedge clk);
        req[2] = 1'b0;
        t_gnt  = 1'b0;
        #1;
        checks++; if (r_valid !== 4'b0100) $display("[TB] FAIL stall_r_valid_in2: got %b expected 0100", r_valid); else passes++;
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        req[1] = 1'b1;
        wen[1] = 1'b0;
        be[1]  = 4'hF;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            add[1]    = 32'h1C00_2000 + 32'(k * 4);
            wdata[1]  = 32'hA5A5_0000 + 32'(k);
            t_gnt     = 1'b1;
            t_r_valid = (k > 0);
            #1;
            checks++; if (gnt !== 4'b0010) $display("[TB] FAIL b2b_gnt[%0d]: got %b expected 0010", k, gnt); else passes++;
            checks++; if (out_bus.wen !== 1'b0) $display("[TB] FAIL b2b_wen[%0d]: got %b expected 0", k, out_bus.wen); else passes++;
            checks++; if (out_bus.be !== 4'hF) $display("[TB] FAIL b2b_be[%0d]: got %h expected f", k, out_bus.be); else passes++;
            checks++; if (out_bus.wdata !== 32'hA5A5_0000 + 32'(k)) $display("[TB] FAIL b2b_wdata[%0d]: got %h expected %h", k, out_bus.wdata, 32'hA5A5_0000 + 32'(k)); else passes++;
            checks++; if (out_bus.add !== 32'h1C00_2000 + 32'(k * 4)) $display("[TB] FAIL b2b_add[%0d]: got %h expected %h", k, out_bus.add, 32'h1C00_2000 + 32'(k * 4)); else passes++;
            @(posedge clk);
            #1;
            checks++; if (int'(dut.state_q) != 1) $display("[TB] FAIL b2b_state[%0d]: got %0d expected 1", k, int'(dut.state_q)); else passes++;
            checks++; if (dut.owner_q !== 2'd1) $display("[TB] FAIL b2b_owner[%0d]: got %0d expected 1", k, dut.owner_q); else passes++;
        end
        @(negedge clk);
        req[1]    = 1'b0;
        t_gnt     = 1'b0;
        t_r_valid = 1'b1;
        #1;
        checks++; if (r_valid !== 4'b0010) $display("[TB] FAIL b2b_last_r_valid: got %b expected 0010", r_valid); else passes++;
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req[0] = 1'b1;
        add[0] = 32'h1C00_3000;
        t_gnt  = 1'b1;
        @(negedge clk);
        rst_n  = 1'b0;
        req[0] = 1'b0;
        t_gnt  = 1'b0;
        #1;
        checks++; if (r_valid !== 4'b0000) $display("[TB] FAIL rmid_r_valid_in_reset: got %b expected 0000", r_valid); else passes++;
        @(negedge clk);
        rst_n     = 1'b1;
        t_r_valid = 1'b1;
        t_r_rdata = 32'hCAFE_F00D;
        #1;
        checks++; if (r_valid !== 4'b0000) $display("[TB] FAIL rmid_late_r_valid: got %b expected 0000", r_valid); else passes++;
        checks++; if (r_rdata[0] !== 32'h0) $display("[TB] FAIL rmid_late_rdata: got %h expected 00000000", r_rdata[0]); else passes++;
        @(negedge clk);
        t_r_valid = 1'b0;
        req       = 4'b0011;
        t_gnt     = 1'b1;
        #1;
        checks++; if (gnt !== 4'b0001) $display("[TB] FAIL rmid_rearb: got %b expected 0001", gnt); else passes++;
        @(negedge clk);
        req       = 4'b0000;
        t_gnt     = 1'b0;
        t_r_valid = 1'b1;
        #1;
        checks++; if (r_valid !== 4'b0001) $display("[TB] FAIL rmid_resp: got %b expected 0001", r_valid); else passes++;
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_stall_lock();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/tcdm_arb_mux.md
TCDM_ARB_MUX -- requirements
Module: tcdm_arb_mux

Interface
REQ-001 SHALL have parameter NR_INPUTS, default 2, giving the number of requesting TCDM ports (legal range 2..16).
REQ-002 SHALL have localparam SEL_WIDTH = $clog2(NR_INPUTS), giving the winner index width.
REQ-003 SHALL have port clk_i, input, 1 bit: clock, rising edge.
REQ-004 SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port test_en_i, input, 1 bit: test enable; has no functional effect.
REQ-006 SHALL have port in_ports[NR_INPUTS], XBAR_TCDM_BUS_36.Slave: requesters (req, add 32, wen, wdata 32, be; gnt, r_valid, r_rdata 32, r_opc).
REQ-007 SHALL have port out_port, XBAR_TCDM_BUS_36.Master: the single shared TCDM target.

Function
REQ-008 SHALL keep at most one transaction outstanding on out_port.
REQ-009 SHALL implement an FSM with states IDLE and PENDING; PENDING means a granted request awaits r_valid.
REQ-010 SHALL select the winner among asserted in_ports[i].req by round-robin: highest priority goes to index (last_winner+1) mod NR_INPUTS.
REQ-011 SHALL update last_winner only on the out_port handshake (out_port.req & out_port.gnt).
REQ-012 SHALL, while out_port.req=1 and gnt=0, lock the winner: re-arbitration is forbidden until gnt or until that requester drops req.
REQ-013 SHALL drive out_port.add/wen/wdata/be combinationally from the winner; with no request: add='0, wen=1, wdata='0, be='0.
REQ-014 SHALL in IDLE drive out_port.req = OR of all in_ports[i].req; gnt=1 at handshake moves the FSM to PENDING and stores owner_q = winner.
REQ-015 SHALL pass out_port.gnt combinationally to the winner's gnt only; all other gnt=0; zero-cycle grant latency.
REQ-016 SHALL in PENDING route r_valid/r_rdata/r_opc only to in_ports[owner_q]; all others r_valid=0, r_rdata='0, r_opc=0.
REQ-017 SHALL in PENDING with r_valid=0 hold out_port.req=0 and all gnt=0.
REQ-018 SHALL in PENDING with r_valid=1 accept a back-to-back request in the same cycle: arbitration runs, gnt -> stay PENDING with new owner_q; no gnt -> IDLE, winner remains locked.
REQ-019 SHALL in PENDING with r_valid=1 and no requests go to IDLE.
REQ-020 SHALL give a single requester 100% throughput: one transaction per cycle when the target grants and responds in 1 cycle.
REQ-021 SHALL, when the locked requester drops req before gnt (protocol violation), release the lock and re-arbitrate in the next cycle without a handshake.

Reset
REQ-022 SHALL on rst_ni=0 asynchronously set state=IDLE, owner_q='0, last_winner=NR_INPUTS-1 (index 0 first priority), lock=0.
REQ-023 SHALL while in reset drive out_port.req=0, all gnt=0, all r_valid=0.
REQ-024 SHALL, on reset mid-transaction, discard the outstanding transaction; a late r_valid in IDLE is ignored and not forwarded.

Structure
REQ-025 SHALL keep the state enum (IDLE, PENDING) local; the shared constants (bus widths 32/32) SHALL reside in pkg_soc_interconnect.
REQ-026 SHALL place round-robin and lock logic in one sub-module, tcdm_rr_sel (inputs req vector, handshake, lock; output index).
REQ-027 SHALL explode the interface arrays with the TCDM explode macros from tcdm_macros.svh.

Verification
REQ-028 SHALL cover: reset, in0 read add=0x1C00_0000, target gnt same cycle, r_valid next cycle, rdata=0xDEAD_BEEF -> in0 gnt in cycle 0, in0 r_valid=1 with 0xDEAD_BEEF in cycle 1, in1 r_valid=0 throughout.
REQ-029 SHALL cover: NR_INPUTS=4, all req held for 8 handshakes -> winner order 0,1,2,3,0,1,2,3.
REQ-030 SHALL cover: target stalls gnt for 3 cycles while in0 is locked and in2 raises req -> out_port.add stays in0's address; in0 is granted, then in2.
REQ-031 SHALL cover: in1 issues back-to-back writes (wen=0, be=0xF) with gnt and r_valid every cycle -> one write per cycle, state remains PENDING, owner_q=1.
REQ-032 SHALL cover: rst_ni asserted while PENDING, then r_valid=1 pulsed after release -> no in_ports r_valid; next request is arbitrated from index 0.
